// File: rtl/map_mem_arbiter.sv
`timescale 1ns/1ps
// map_mem_arbiter
//
// Purpose: shares one single-port, synchronous-read map RAM between the
// video pixel-fetch path (read only, highest priority) and the CPU-side game
// interface (read/write, level request with ack). At most one RAM access is
// issued per cycle and the result is returned two cycles after the request
// was sampled.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   defined   - starvation counter bounds the CPU wait; after STARVE_MAX
//               consecutive video grants against an eligible CPU, the CPU
//               wins and the dropped video request is flagged on vid_miss.
//   undefined - strict video priority, vid_miss tied low, no counter.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   vid_req, vid_addr          video read request (single-cycle pulse)
//   vid_valid, vid_rdata       video read result (pulse + data)
//   vid_miss                   video request dropped by the guard
//   cpu_req, cpu_we,
//   cpu_addr, cpu_wdata        CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_rdata         CPU completion pulse, last read data (held)
//   ram_en, ram_we, ram_addr,
//   ram_wdata                  registered RAM command
//   ram_rdata                  RAM read data, valid the cycle after ram_en

module map_mem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Owner tag carried down the result pipeline. Bit 1 set means CPU.
    localparam logic [1:0] TAG_NONE   = 2'd0;
    localparam logic [1:0] TAG_VID    = 2'd1;
    localparam logic [1:0] TAG_CPU_RD = 2'd2;
    localparam logic [1:0] TAG_CPU_WR = 2'd3;

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("map_mem_arbiter: STARVE_MAX must be in 1..255");
    end

    logic [1:0]        tag_p1_q, tag_p1_d;
    logic [1:0]        tag_p2_q, tag_p2_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] vid_hold_q, vid_hold_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;

    logic cpu_elig;
    logic guard_trip;
    logic grant_cpu;
    logic grant_vid;

    // A CPU access is outstanding from its grant through its ack, i.e. while
    // its tag sits in either pipeline stage.
    assign cpu_elig  = cpu_req && !tag_p1_q[1] && !tag_p2_q[1];
    assign grant_cpu = cpu_elig && (!vid_req || guard_trip);
    assign grant_vid = vid_req && !grant_cpu;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       vid_miss_q, vid_miss_d;

    assign guard_trip = cpu_elig && (starve_cnt_q == STARVE_LIM);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!cpu_req || grant_cpu) begin
            starve_cnt_d = 8'd0;
        end else if (grant_vid && cpu_elig && (starve_cnt_q < STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
        // Only a guard override can grant the CPU while video is requesting.
        vid_miss_d = vid_req && grant_cpu;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 8'd0;
            vid_miss_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            vid_miss_q   <= vid_miss_d;
        end
    end

    assign vid_miss = vid_miss_q;
`else
    assign guard_trip = 1'b0;
    assign vid_miss   = 1'b0;
`endif

    always_comb begin
        // Stage 0 -> 1: arbitration result becomes the registered RAM command.
        tag_p1_d    = TAG_NONE;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (grant_cpu) begin
            tag_p1_d   = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
            ram_en_d   = 1'b1;
            ram_we_d   = cpu_we;
            ram_addr_d = cpu_addr;
            if (cpu_we) begin
                ram_wdata_d = cpu_wdata;
            end
        end else if (grant_vid) begin
            tag_p1_d   = TAG_VID;
            ram_en_d   = 1'b1;
            ram_addr_d = vid_addr;
        end

        // Stage 1 -> 2: the RAM access cycle hands its tag to the return stage.
        tag_p2_d = tag_p1_q;

        // Stage 2 hold: remember the last returned data once its pulse is over.
        vid_hold_d = (tag_p2_q == TAG_VID)    ? ram_rdata : vid_hold_q;
        cpu_hold_d = (tag_p2_q == TAG_CPU_RD) ? ram_rdata : cpu_hold_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_p1_q    <= TAG_NONE;
            tag_p2_q    <= TAG_NONE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            vid_hold_q  <= '0;
            cpu_hold_q  <= '0;
        end else begin
            tag_p1_q    <= tag_p1_d;
            tag_p2_q    <= tag_p2_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            vid_hold_q  <= vid_hold_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    // The block RAM's own output register is the data register of the return
    // stage: during the result cycle its output is forwarded directly, so the
    // two-cycle latency holds; afterwards the captured copy is presented.
    assign vid_valid = (tag_p2_q == TAG_VID);
    assign cpu_ack   = tag_p2_q[1];
    assign vid_rdata = vid_valid ? ram_rdata : vid_hold_q;
    assign cpu_rdata = (tag_p2_q == TAG_CPU_RD) ? ram_rdata : cpu_hold_q;

endmodule

// File: tb/tb_map_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for map_mem_arbiter: directed scenarios plus a
// randomized phase. A behavioural model predicts every result and its cycle;
// a negedge monitor compares DUT outputs against the predicted queues.
module tb_map_mem_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 8;
    localparam int STARVE_MAX = 3;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_miss;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    map_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_valid(vid_valid),
        .vid_rdata(vid_rdata),
        .vid_miss (vid_miss),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM environment model: synchronous read, data the cycle after ram_en.
    logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: shadow memory, per-requester expectation queues with
    // the cycle in which each result must appear.
    typedef struct { int due; logic [DATA_W-1:0] data; } exp_t;
    exp_t vid_q[$];
    exp_t cpu_q[$];
    int   miss_q[$];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    int   cyc = 0;
    int   busy = 0;
    int   starve = 0;
    logic [DATA_W-1:0] last_rd = '0;
    bit   m_elig, m_trip, m_gc, m_gv;

    always @(posedge clk) begin
        if (reset) begin
            vid_q.delete();
            cpu_q.delete();
            miss_q.delete();
            busy    = 0;
            starve  = 0;
            last_rd = '0;
        end else begin
            m_elig = cpu_req && (busy == 0);
            m_trip = GUARD && m_elig && (starve == STARVE_MAX);
            m_gc   = m_elig && (!vid_req || m_trip);
            m_gv   = vid_req && !m_gc;
            if (m_gv) vid_q.push_back('{cyc + 2, ref_mem[vid_addr]});
            if (m_gc) begin
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else        last_rd = ref_mem[cpu_addr];
                cpu_q.push_back('{cyc + 2, last_rd});
                busy = 2;
            end else if (busy > 0) begin
                busy--;
            end
            if (m_gc && vid_req) miss_q.push_back(cyc + 1);
            if (!cpu_req || m_gc) starve = 0;
            else if (m_gv && m_elig && starve < STARVE_MAX) starve++;
        end
        cyc = cyc + 1;
    end

    int vv_cnt = 0;
    int ack_cnt = 0;
    int miss_cnt = 0;
    exp_t m_e;
    int   m_d;

    always @(negedge clk) begin
        if (vid_valid === 1'b1) begin
            vv_cnt++;
            if (vid_q.size() == 0) chk("vid_unexpected", 1, 0);
            else begin
                m_e = vid_q.pop_front();
                chk("vid_cycle", cyc, m_e.due);
                chk("vid_rdata", vid_rdata, m_e.data);
            end
        end else if (vid_q.size() > 0 && vid_q[0].due <= cyc) begin
            m_e = vid_q.pop_front();
            chk("vid_missing", 0, 1);
        end
        if (cpu_ack === 1'b1) begin
            ack_cnt++;
            if (cpu_q.size() == 0) chk("cpu_unexpected", 1, 0);
            else begin
                m_e = cpu_q.pop_front();
                chk("cpu_cycle", cyc, m_e.due);
                chk("cpu_rdata", cpu_rdata, m_e.data);
            end
        end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
            m_e = cpu_q.pop_front();
            chk("cpu_missing", 0, 1);
        end
        if (vid_miss === 1'b1) begin
            miss_cnt++;
            if (miss_q.size() == 0) chk("miss_unexpected", 1, 0);
            else begin
                m_d = miss_q.pop_front();
                chk("miss_cycle", cyc, m_d);
            end
        end else if (miss_q.size() > 0 && miss_q[0] <= cyc) begin
            m_d = miss_q.pop_front();
            chk("miss_missing", 0, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vid_valid"}, vid_valid, 0);
        chk({tag, "_vid_rdata"}, vid_rdata, 0);
        chk({tag, "_vid_miss"},  vid_miss, 0);
        chk({tag, "_cpu_ack"},   cpu_ack, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_ram_en"},    ram_en, 0);
        chk({tag, "_ram_we"},    ram_we, 0);
        chk({tag, "_ram_addr"},  ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
    endtask

    int a0, v0, m0;

    initial begin
        logic [DATA_W-1:0] b;
        reset     = 1'b1;
        vid_req   = 1'b0;
        vid_addr  = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ram_rdata <= '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            b = DATA_W'($urandom);
            if (i == 16'h0010) b = 8'hA5;
            ram_mem[i] <= b;
            ref_mem[i] = b;
        end

        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        // Single video read.
        vid_req = 1'b1; vid_addr = 14'h0010;
        step();
        vid_req = 1'b0;
        chk("t1_ram_en", ram_en, 1);
        chk("t1_ram_addr", ram_addr, 32'h0010);
        chk("t1_ram_we", ram_we, 0);
        step();
        chk("t1_vid_valid", vid_valid, 1);
        chk("t1_vid_rdata", vid_rdata, 32'hA5);
        step();

        // CPU write then read-back.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0123; cpu_wdata = 8'h3C;
        step();
        chk("t2_wr_ram_we", ram_we, 1);
        chk("t2_wr_ram_addr", ram_addr, 32'h0123);
        chk("t2_wr_ram_wdata", ram_wdata, 32'h3C);
        step();
        chk("t2_wr_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0;
        step();
        chk("t2_rd_ram_we", ram_we, 0);
        step();
        chk("t2_rd_ack", cpu_ack, 1);
        chk("t2_rd_data", cpu_rdata, 32'h3C);
        cpu_req = 1'b0;
        vid_req = 1'b1; vid_addr = 14'h0010;
        step();
        vid_req = 1'b0;
        step();
        step();
        chk("t2_rdata_hold", cpu_rdata, 32'h3C);

        // Simultaneous requests: video first, CPU next cycle.
        vid_req = 1'b1; vid_addr = 14'h0200;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        step();
        vid_req = 1'b0;
        chk("t3_first_addr", ram_addr, 32'h0200);
        step();
        chk("t3_second_addr", ram_addr, 32'h0123);
        chk("t3_no_early_ack", cpu_ack, 0);
        step();
        chk("t3_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        step();

        // Continuous video with CPU request held for 100 cycles.
        a0 = ack_cnt; v0 = vv_cnt; m0 = miss_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        for (int i = 0; i < 100; i++) begin
            vid_req  = 1'b1;
            vid_addr = ADDR_W'($urandom_range(0, 63));
            step();
            cpu_req = !cpu_ack;
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        repeat (4) step();
`ifdef ARB_STARVE_GUARD_EN
        chk("t4_miss_seen", (miss_cnt - m0) > 0, 1);
        chk("t4_acks_eq_miss", ack_cnt - a0, miss_cnt - m0);
        chk("t4_vid_plus_miss", (vv_cnt - v0) + (miss_cnt - m0), 100);
`else
        chk("t4_no_ack", ack_cnt - a0, 0);
        chk("t4_no_miss", miss_cnt - m0, 0);
        chk("t4_vid_count", vv_cnt - v0, 100);
`endif

        // Reset in the cycle after a CPU read grant.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        step();
        reset = 1'b1; cpu_req = 1'b0;
        step();
        chk_all_zero("t5");
        reset = 1'b0;
        step();

        // Randomized traffic over a small address window, one reset pulse.
        for (int i = 0; i < 300; i++) begin
            reset    = (i == 150);
            vid_req  = ($urandom_range(0, 2) != 0);
            vid_addr = ADDR_W'($urandom_range(0, 31));
            if (cpu_req && cpu_ack) begin
                cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = ADDR_W'($urandom_range(0, 31));
                cpu_wdata = DATA_W'($urandom);
            end
            step();
        end
        reset   = 1'b0;
        vid_req = 1'b0;
        cpu_req = 1'b0;
        repeat (5) step();
        chk("drain_vid", vid_q.size(), 0);
        chk("drain_cpu", cpu_q.size(), 0);
        chk("drain_miss", miss_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_mem_arbiter.md
# map_mem_arbiter

Shares one single-port, synchronous-read map RAM between two requesters. The video path issues pixel-fetch reads. The PicoBlaze-side game interface issues reads and writes. The arbiter issues at most one RAM access per cycle and pipelines the result back to whichever requester owns it. Video has priority; an optional starvation guard bounds how long the CPU can wait. It sits between video_game_controller, game_interface and the map block RAM on the 100 MHz system clock.

## Interface
Parameters:
- ADDR_W, 14, map RAM address width
- DATA_W, 8, map RAM data width
- STARVE_MAX, 15, consecutive video grants tolerated while the CPU waits (guard only); legal range 1..255

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- vid_req  in  1  video read request; single-cycle pulse, one request per cycle max
- vid_addr  in  ADDR_W  video read address, valid with vid_req
- vid_valid  out  1  one-cycle pulse: vid_rdata holds data for an earlier vid_req
- vid_rdata  out  DATA_W  video read data, registered
- vid_miss  out  1  one-cycle pulse: a vid_req was dropped by the guard
- cpu_req  in  1  CPU request; level signal held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle pulse: CPU access complete
- cpu_rdata  out  DATA_W  CPU read data; updated only on a read ack, held otherwise
- ram_en  out  1  RAM enable, registered
- ram_we  out  1  RAM write enable, registered
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en

## Operation
- Decision in cycle N is made from the inputs sampled at the end of cycle N.
  - Pipeline tag becomes VID, CPU_RD, CPU_WR or NONE.
- CPU eligibility:
  - cpu_req is high, and
  - no CPU access is outstanding. An access is outstanding from its grant cycle through its cpu_ack cycle inclusive.
- Priority:
  - If vid_req is high, video is granted.
  - Otherwise, if the CPU is eligible, the CPU is granted.
  - Otherwise no access is issued.
- Guard override (macro only): when starve_cnt == STARVE_MAX and the CPU is eligible:
  - The CPU is granted even if vid_req is high.
  - The dropped video request raises vid_miss in cycle N+1.
- starve_cnt (8-bit):
  - Increments on each video grant while the CPU is eligible.
  - Clears on a CPU grant or whenever cpu_req is low.
  - Saturates at STARVE_MAX.
- Two-stage result pipeline: stage 1 is the RAM access, stage 2 is the return register.
  - Writes return cpu_ack with no data change.
  - Reads capture ram_rdata into vid_rdata or cpu_rdata.
- CPU requester handshake: cpu_req must drop in the cycle after cpu_ack. If it is still high there, that is treated as a new request.
- Reset, including mid-operation:
  - Clears all pipeline tags and starve_cnt.
  - In-flight accesses are discarded, and no valid or ack is produced for them.
  - A write whose ram_we was already registered may still complete in the RAM.

## Timing
- Request sampled in cycle N.
- ram_en/ram_we/ram_addr/ram_wdata driven in cycle N+1.
- vid_valid or cpu_ack high in cycle N+2, with data registered.
- Fixed latency: 2 cycles request-to-result.
- Throughput: one video read per cycle sustained.
- Minimum spacing between CPU grants: 3 cycles (grant, access, ack).
- Reset values: all outputs 0, including vid_rdata, cpu_rdata and ram_*.
- Simultaneous vid_req and cpu_req with the guard not tripped: video wins; the CPU waits with no loss.
- ram_en is 0 in any cycle with no grant; ram_addr and ram_wdata hold their last values.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - starve_cnt, the guard override and vid_miss are implemented.
  - Worst-case CPU wait from eligibility to grant is STARVE_MAX+1 cycles.
- ARB_STARVE_GUARD_EN undefined:
  - Strict video priority; the CPU may wait indefinitely.
  - vid_miss is tied 0 and no counter logic is synthesized.

## Test plan
- Reset released; vid_req pulse at addr 0x0010 with RAM model returning 0xA5 → ram_en at N+1 with ram_addr 0x0010; vid_valid at N+2 with vid_rdata 0xA5.
- CPU write addr 0x0123 data 0x3C, then read of 0x0123 → ram_we=1 at N+1; cpu_ack at N+2; read ack returns cpu_rdata 0x3C, held until the next read ack.
- vid_req and cpu_req both high in one cycle, then vid_req low → video granted first; CPU granted the following cycle; ack 2 cycles later.
- Guard on, STARVE_MAX=3, continuous vid_req with cpu_req held → 3 video grants, then a CPU grant; vid_miss pulse once; video resumes the next cycle.
- Guard off, same stimulus for 100 cycles → no cpu_ack, vid_miss stays 0, 100 vid_valid pulses.
- Reset asserted in the cycle after a CPU read grant → no cpu_ack; all outputs 0 the next cycle; starve_cnt 0.
